// File: rtl/alu_result_retire.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_result_retire: 2-entry skid FIFO retiring ALU results in order,       |
// | committing NZCV on retirement and evaluating condition codes. Rev 1.0     |
// +----------------------------------------------------------------------------+
module alu_result_retire #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_zerof,
  input  logic             in_negf,
  input  logic             in_overf,
  input  logic             in_carry,
  input  logic             in_setf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       flags,
  input  logic [3:0]       cond,
  output logic             cond_pass
);

  localparam logic [1:0] c_depth = 2'(DEPTH);

  // meta entry layout: {negf, zerof, carry, overf, setf}
  logic [WIDTH-1:0] result_q [DEPTH];
  logic [WIDTH-1:0] result_d [DEPTH];
  logic [4:0]       meta_q   [DEPTH];
  logic [4:0]       meta_d   [DEPTH];
  logic [1:0]       count_q, count_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [3:0]       flags_q, flags_d;
  logic             w_push, w_pop;
  logic [4:0]       w_head_meta;

  assign in_ready    = (count_q < c_depth);
  assign out_valid   = (count_q != 2'd0);
  assign out_result  = result_q[rd_ptr_q];
  assign w_head_meta = meta_q[rd_ptr_q];
  assign flags       = flags_q;
  assign w_push      = in_valid & in_ready;
  assign w_pop       = out_valid & out_ready;

  always_comb begin
    result_d = result_q;
    meta_d   = meta_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    flags_d  = flags_q;
    if (w_push) begin
      result_d[wr_ptr_q] = in_result;
      meta_d[wr_ptr_q]   = {in_negf, in_zerof, in_carry, in_overf, in_setf};
      wr_ptr_d           = ~wr_ptr_q;
    end
    if (w_pop) begin
      rd_ptr_d = ~rd_ptr_q;
      if (w_head_meta[0]) begin
        flags_d = w_head_meta[4:1];
      end
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      flags_q  <= 4'b0000;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      flags_q  <= flags_d;
    end
  end

  // Payload storage needs no reset: it is only observable behind out_valid.
  always_ff @(posedge clk) begin
    result_q <= result_d;
    meta_q   <= meta_d;
  end

  logic w_n, w_z, w_c, w_v;
  assign {w_n, w_z, w_c, w_v} = flags_q;

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'h0: cond_pass = w_z;
      4'h1: cond_pass = ~w_z;
      4'h2: cond_pass = w_c;
      4'h3: cond_pass = ~w_c;
      4'h4: cond_pass = w_n;
      4'h5: cond_pass = ~w_n;
      4'h6: cond_pass = w_v;
      4'h7: cond_pass = ~w_v;
      4'h8: cond_pass = w_c & ~w_z;
      4'h9: cond_pass = ~w_c | w_z;
      4'hA: cond_pass = (w_n == w_v);
      4'hB: cond_pass = (w_n != w_v);
      4'hC: cond_pass = ~w_z & (w_n == w_v);
      4'hD: cond_pass = w_z | (w_n != w_v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_result_retire.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_result_retire: directed + randomized bench with a queue-based      |
// | reference model of the retire buffer and NZCV register. Rev 1.0           |
// +----------------------------------------------------------------------------+
module tb_alu_result_retire;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_zerof, in_negf, in_overf, in_carry, in_setf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  flags;
  logic [3:0]  cond;
  logic        cond_pass;

  always #5 clk = ~clk;

  alu_result_retire #(.WIDTH(32), .DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_result (in_result),
    .in_zerof  (in_zerof),
    .in_negf   (in_negf),
    .in_overf  (in_overf),
    .in_carry  (in_carry),
    .in_setf   (in_setf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .flags     (flags),
    .cond      (cond),
    .cond_pass (cond_pass)
  );

  typedef struct {
    logic [31:0] result;
    logic [3:0]  nzcv;
    bit          setf;
  } entry_t;

  entry_t      m_q[$];
  logic [3:0]  m_flags;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Condition codes come in true/inverted pairs; bit 0 selects the inversion.
  function automatic bit cond_ref(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic step(input bit v, input logic [31:0] d, input logic [3:0] nzcv, input bit sf,
                      input bit ordy, input logic [3:0] c, input bit rstn);
    bit do_pop, do_push;
    entry_t e;
    @(negedge clk);
    reset     = rstn;
    in_valid  = v;
    in_result = d;
    {in_negf, in_zerof, in_carry, in_overf} = nzcv;
    in_setf   = sf;
    out_ready = ordy;
    cond      = c;
    #1;
    check_val("in_ready", {31'd0, in_ready}, {31'd0, m_q.size() < 2});
    check_val("out_valid", {31'd0, out_valid}, {31'd0, m_q.size() != 0});
    if (m_q.size() != 0) check_val("out_result", out_result, m_q[0].result);
    check_val("flags", {28'd0, flags}, {28'd0, m_flags});
    check_val("cond_pass", {31'd0, cond_pass}, {31'd0, cond_ref(c, m_flags)});
    @(posedge clk);
    if (!rstn) begin
      m_q.delete();
      m_flags = 4'b0000;
    end else begin
      do_pop  = ordy && (m_q.size() != 0);
      do_push = v && (m_q.size() < 2);
      if (do_pop) begin
        e = m_q.pop_front();
        if (e.setf) m_flags = e.nzcv;
      end
      if (do_push) begin
        e.result = d;
        e.nzcv   = nzcv;
        e.setf   = sf;
        m_q.push_back(e);
      end
    end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_result = '0; in_zerof = 1'b0; in_negf = 1'b0;
    in_overf = 1'b0; in_carry = 1'b0; in_setf = 1'b0; out_ready = 1'b0; cond = 4'h0;
    m_flags = 4'b0000;
    repeat (2) @(posedge clk);

    // Reset/idle with AL and EQ
    step(0, 0, 4'h0, 0, 0, 4'hE, 1);
    step(0, 0, 4'h0, 0, 0, 4'h0, 1);

    // Fill and stall, then ordered retirement with flag commit
    step(1, 32'h0000_0000, 4'b0100, 1, 0, 4'h0, 1);
    step(1, 32'h8000_0000, 4'b1000, 1, 0, 4'h0, 1);
    step(1, 32'h1234_5678, 4'b0000, 0, 0, 4'h0, 1);
    step(1, 32'h1234_5678, 4'b0000, 0, 0, 4'h0, 1);
    step(1, 32'h1234_5678, 4'b0000, 0, 1, 4'h0, 1);
    step(1, 32'h1234_5678, 4'b0000, 0, 1, 4'h4, 1);
    step(0, 0, 4'h0, 0, 1, 4'h4, 1);
    step(0, 0, 4'h0, 0, 1, 4'h4, 1);
    step(0, 0, 4'h0, 0, 1, 4'h4, 1);

    // setf gating: load Z, then retire a non-committing negative result
    step(1, 32'h0000_0000, 4'b0100, 1, 1, 4'h0, 1);
    step(1, 32'hFFFF_FFFF, 4'b1000, 0, 1, 4'h0, 1);
    step(0, 0, 4'h0, 0, 1, 4'h0, 1);
    step(0, 0, 4'h0, 0, 1, 4'h0, 1);

    // Streaming 1..8 through the count==1 push/pop path
    for (int i = 1; i <= 8; i++) step(1, i, 4'h0, 0, 1, 4'hE, 1);
    step(0, 0, 4'h0, 0, 1, 4'hE, 1);
    step(0, 0, 4'h0, 0, 1, 4'hE, 1);

    // Full condition table over every committed NZCV value
    for (int f = 0; f < 16; f++) begin
      step(1, $urandom, 4'(f), 1, 0, 4'h0, 1);
      step(0, 0, 4'h0, 0, 1, 4'h0, 1);
      for (int c = 0; c < 16; c++) step(0, 0, 4'h0, 0, 0, 4'(c), 1);
    end

    // Reset mid-operation with two committing entries buffered
    step(1, 32'hDEAD_BEEF, 4'b1111, 1, 0, 4'hE, 1);
    step(1, 32'hCAFE_F00D, 4'b1010, 1, 0, 4'hE, 1);
    step(0, 0, 4'h0, 0, 1, 4'hE, 0);
    step(0, 0, 4'h0, 0, 1, 4'h1, 1);
    step(0, 0, 4'h0, 0, 1, 4'h1, 1);

    // Randomized traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 3) != 0, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)), $urandom_range(0, 49) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_result_retire.md
Name: alu_result_retire

Overview:
- Consumer end of the ALU datapath interface: accepts the 32-bit result plus zerof/negf/overf/carry from any ALU slice through a valid/ready handshake.
- Buffers up to two results in a skid FIFO and retires them in order to the writeback stage.
- On retirement, commits the flags into an architectural NZCV register when the op requested it.
- Evaluates a 4-bit condition code against the committed flags for branch/predication decisions.

Parameters:
- WIDTH, 32, result data width.
- DEPTH, 2, FIFO entries. Fixed at 2; other values are not supported.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  ALU result/flags present.
- in_ready  output  1  buffer can accept.
- in_result  input  WIDTH  ALU out.
- in_zerof  input  1  ALU zero flag.
- in_negf  input  1  ALU negative flag.
- in_overf  input  1  ALU overflow flag.
- in_carry  input  1  ALU carry flag.
- in_setf  input  1  op updates flags on retirement.
- out_valid  output  1  head entry available.
- out_ready  input  1  writeback accepts head.
- out_result  output  WIDTH  head entry result.
- flags  output  4  committed {N,Z,C,V}.
- cond  input  4  condition code to evaluate.
- cond_pass  output  1  cond satisfied by flags.

Behaviour:
- Reset (reset==0 at clk edge):
  - Count, read pointer and write pointer all return to 0.
  - flags=4'b0000, out_valid=0, in_ready=1.
  - out_result is don't-care but driven from storage, never X-propagating logic.
  - Reset mid-operation discards all buffered entries; no flag commit occurs on the reset edge.
- Each entry stores {result, negf, zerof, carry, overf, setf}. The flags are stored exactly as supplied; zerof is not recomputed.
- in_ready = (count < 2), combinational from registered count only. It does not depend on out_ready, so there is no combinational path from out_ready to in_ready.
- Push: in_valid & in_ready. Entry is written at the write pointer; the write pointer wraps 1 -> 0.
- out_valid = (count != 0). out_result and the head fields come from the read pointer.
- Pop: out_valid & out_ready. The read pointer wraps 1 -> 0.
- Simultaneous push and pop with count==1: count stays 1, and the new entry becomes head on the next cycle.
- Simultaneous push and pop with count==0 is impossible, because no pop occurs while empty.
- When count==2, in_ready=0 and in_valid is ignored. The upstream ALU must hold its data.
- A push on the same cycle as out_valid=0 is not visible at the output until the next cycle (1-cycle latency in->out).
- Flag commit: on a pop where head.setf==1, flags <= {head.negf, head.zerof, head.carry, head.overf} at that edge. On a pop with setf==0, flags are unchanged.
- Flags update only at retirement, so a younger buffered op never affects flags before an older one.
- cond_pass is combinational from the registered flags and cond:
  - 0 EQ Z
  - 1 NE !Z
  - 2 CS C
  - 3 CC !C
  - 4 MI N
  - 5 PL !N
  - 6 VS V
  - 7 VC !V
  - 8 HI C&!Z
  - 9 LS !C|Z
  - A GE N==V
  - B LT N!=V
  - C GT !Z&(N==V)
  - D LE Z|(N!=V)
  - E AL 1
  - F NV 0
- A cond evaluated in the same cycle as a committing pop sees the pre-commit flags; there is no bypass.
- Illegal states such as count==3 are unreachable. Count is 2 bits and saturates by construction of in_ready.

Test Plan:
- Reset and idle: hold reset=0 for 2 cycles, then release.
  - Expected: in_ready=1, out_valid=0, flags=0000.
  - cond=E -> cond_pass=1; cond=0 -> cond_pass=0.
- Fill and stall:
  - Stimulus: push 0x00000000 (zerof=1, setf=1) and 0x80000000 (negf=1, setf=1) with out_ready=0; keep in_valid high with 0x12345678.
  - Expected: in_ready=0 after 2 pushes; third value not accepted; count held at 2.
- Ordered retirement and flag commit (continuing the fill scenario):
  - Stimulus: raise out_ready.
  - Expected: out_result=0x00000000 and flags become 0100 on the next cycle; then out_result=0x80000000 and flags become 1000; then 0x12345678 is accepted and retired.
- setf gating:
  - Stimulus: flags=0100; retire 0xFFFFFFFF with negf=1, setf=0.
  - Expected: flags remain 0100; cond=0 (EQ) -> cond_pass=1.
- Concurrent push/pop at count==1: stream 8 consecutive values 1..8 with in_valid and out_ready held high.
  - Expected: outputs 1..8 in order, one per cycle after the 1-cycle latency.
  - Expected: in_ready stays 1 throughout; no drops or duplicates across pointer wrap.
- Condition table and reset mid-operation:
  - Stimulus: for each NZCV value 0000..1111, sweep cond 0..F; cond_pass must match the equations above (256 checks).
  - Stimulus: with 2 entries buffered, assert reset=0 for 1 cycle.
  - Expected: out_valid=0, flags=0000, and buffered data never appears at the output.
